skinny_sbox8_hpc2_1_mlane_hs: RTL and testbench
===============================================

// Module: skinny_sbox8_hpc2_1_mlane_hs
// PURPOSE
//  First-order (2-share) HPC2-masked SKINNY 8-bit S-box bank with NUM_SBOX parallel lanes.
//  Input shares and randomness are captured on a valid/ready handshake, then a 4-level sequencer
//  evaluates the 8 masked NOR-XOR core functions per lane and presents registered output shares.
//  Upstream logic no longer has to hold inputs or masks stable. Sits between state/tweakey share
//  registers and the masked round datapath.
// PARAMETERS
//  NUM_SBOX  4  parallel S-box lanes; legal range 1..16
//  SW        8  S-box width; fixed and checked by elaboration assert
//  RW        16 fresh random bits per lane per operation
// PORTS
//  clk        in   1           single clock, posedge only
//  rst        in   1           synchronous, active-high reset
//  in_valid   in   1           input shares and rnd are valid
//  in_ready   out  1           block can accept a new operation
//  si0        in   8*NUM_SBOX  share 0; lane k = bits [8k+7:8k]
//  si1        in   8*NUM_SBOX  share 1
//  rnd        in   16*NUM_SBOX fresh randomness; lane k = [16k+15:16k]
//  out_valid  out  1           output shares valid
//  out_ready  in   1           consumer accepts output
//  bo0        out  8*NUM_SBOX  output share 0
//  bo1        out  8*NUM_SBOX  output share 1
// BEHAVIOUR
//  - Function: per lane, bo0^bo1 == SKINNY_S8(si0^si1) for the accepted operation.
//  - Reset (clk edge with rst=1): state=IDLE, in_ready=1, out_valid=0, bo0=bo1=0,
//    all internal share and gadget registers=0. Applies mid-operation; the in-flight
//    operation is discarded and never produces out_valid.
//  - FSM states: IDLE, RUN (cnt 0..7), DONE.
//    IDLE -> RUN on in_valid&in_ready: si0, si1 and rnd are latched; cnt=0.
//    RUN: cnt+1 each cycle; level L=cnt>>1 (0..3); phase=cnt[0]. RUN -> DONE when cnt=7.
//    DONE: out_valid=1; leave when out_ready=1.
//  - Gadget cfn(a,b,z,r[1:0]) computes f = (~a & ~b) ^ z. It is an HPC2 AND on x=~a and
//    y=~b^r[1] (b refreshed).
//    Phase 0 registers y, r[0]&~x0 and r[0]&~x1.
//    Phase 1 registers x0&y0_reg, x1&y1_reg, x0&(y1^r0) and x1&(y0^r0), then XORs in z.
//    A gadget's registers update only in its own level's phases; otherwise they hold.
//  - Schedule (bi = latched input bits, rnd slice in brackets):
//    L0: a0=cfn(b7,b6,b4,[1:0])   a1=cfn(b3,b2,b0,[3:2])   a2=cfn(b2,b1,b6,[5:4])
//    L1: a3=cfn(a0,a1,b5,[7:6])   a4=cfn(a1,b3,b1,[9:8])
//    L2: a5=cfn(a2,a3,b7,[11:10]) a6=cfn(a3,a0,b3,[13:12])
//    L3: a7=cfn(a4,a5,b2,[15:14])
//    Output bits: bo[6]=a0 bo[5]=a1 bo[2]=a2 bo[7]=a3 bo[3]=a4 bo[1]=a5 bo[4]=a6 bo[0]=a7.
//  - bo0/bo1 load from the gadget outputs on the RUN(cnt=7) -> DONE edge only.
//    They never show intermediate values and hold until the next load or reset.
//  - Latency: acceptance at edge t gives out_valid=1 after edge t+8.
//  - in_ready = IDLE | (DONE & out_ready). Back-to-back: output handoff and new accept happen
//    on the same edge, giving 1 op per 9 cycles. With out_ready=0, DONE holds and bo is stable.
//  - in_valid while busy is ignored, with no capture. si and rnd may change freely once accepted.
//  - Lanes are fully independent. No rnd bit is shared between lanes or between gadgets.
// STRUCTURE
//  - Package skinny_masked_pkg: SW=8, RW=16, LEVELS=4, CYC_PER_LEVEL=2, FSM state encoding,
//    per-gadget operand/rnd-slice table, output bit permutation.
//  - Sub-module hpc2_1_sbox8_cfn_sync: posedge-only two-phase cfn gadget with en_p0/en_p1
//    and sync reset. Instantiated 8 x NUM_SBOX via generate.
//  - Top holds the handshake FSM, counter, capture registers and output registers.
// TESTING
//  1 si0=00 si1=00 rnd=0, one lane -> out_valid 8 cycles after accept, bo0^bo1=65.
//  2 si0=A5 si1=5A (x=FF), random rnd -> bo0^bo1=FF; repeating with new rnd changes bo0 but not
//    the XOR.
//  3 Exhaustive: all 256 x with random splits and rnd, NUM_SBOX=4 with distinct x per lane ->
//    every lane matches the golden S8 table.
//  4 out_ready=0 for 20 cycles after DONE -> bo stable, in_ready=0, new in_valid ignored; then
//    out_ready=1 with in_valid=1 -> handoff and accept on the same edge.
//  5 rst pulse at cnt=4 -> next cycle in_ready=1, out_valid=0, bo=0; the next op completes
//    correctly.
//  6 si/rnd toggled randomly every cycle during RUN -> result equals the values captured at
//    accept.

Source files
------------

// File: rtl/skinny_masked_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | skinny_masked_pkg                                                          |
// | Shared constants, FSM encoding and gadget schedule of the masked S8 bank.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package skinny_masked_pkg;

  localparam int SW            = 8;
  localparam int RW            = 16;
  localparam int LEVELS        = 4;
  localparam int CYC_PER_LEVEL = 2;
  localparam int NUM_CFN       = 8;
  localparam int CNT_W         = $clog2(LEVELS * CYC_PER_LEVEL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEVELS * CYC_PER_LEVEL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Operand codes 0..7 select input bit b[i]; 8..14 select gadget output a[code-8].
  // The z operand is always an input bit. rnd slice of gadget g is [2g+1:2g].
  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [2:0] src_z;
    logic [1:0] level;
    logic [2:0] obit;
  } cfn_cfg_t;

  function automatic cfn_cfg_t cfn_cfg(input int g);
    cfn_cfg_t c;
    case (g)
      0:       c = {4'd7,  4'd6,  3'd4, 2'd0, 3'd6};
      1:       c = {4'd3,  4'd2,  3'd0, 2'd0, 3'd5};
      2:       c = {4'd2,  4'd1,  3'd6, 2'd0, 3'd2};
      3:       c = {4'd8,  4'd9,  3'd5, 2'd1, 3'd7};
      4:       c = {4'd9,  4'd3,  3'd1, 2'd1, 3'd3};
      5:       c = {4'd10, 4'd11, 3'd7, 2'd2, 3'd1};
      6:       c = {4'd11, 4'd8,  3'd3, 2'd2, 3'd4};
      7:       c = {4'd12, 4'd13, 3'd2, 2'd3, 3'd0};
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic logic pick(input logic [3:0] code, input logic [SW-1:0] b,
                                input logic [NUM_CFN-2:0] a);
    return code[3] ? a[code[2:0]] : b[code[2:0]];
  endfunction

  function automatic logic [SW-1:0] perm_out(input logic [NUM_CFN-1:0] a);
    logic [SW-1:0] o;
    cfn_cfg_t      c;
    o = '0;
    for (int g = 0; g < NUM_CFN; g++) begin
      c         = cfn_cfg(g);
      o[c.obit] = a[g];
    end
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hpc2_1_sbox8_cfn_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hpc2_1_sbox8_cfn_sync                                                      |
// | Two-phase HPC2 masked gadget computing f = (~a & ~b) ^ z on two shares.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module hpc2_1_sbox8_cfn_sync #(
  parameter bit OUT_NEXT = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_p0_i,
  input  logic       en_p1_i,
  input  logic       a0_i,
  input  logic       a1_i,
  input  logic       b0_i,
  input  logic       b1_i,
  input  logic       z0_i,
  input  logic       z1_i,
  input  logic [1:0] r_i,
  output logic       f0_o,
  output logic       f1_o
);

  logic x0, x1, y0_d, y1_d;
  logic y0_q, y1_q, u0_q, u1_q;
  logic m0_d, m1_d, c0_d, c1_d;

  // Negation lands on share 0 only; b is refreshed with r[1] before the AND.
  assign x0   = ~a0_i;
  assign x1   = a1_i;
  assign y0_d = ~b0_i ^ r_i[1];
  assign y1_d = b1_i ^ r_i[1];

  assign m0_d = x0 & y0_q;
  assign m1_d = x1 & y1_q;
  assign c0_d = x0 & (y1_q ^ r_i[0]);
  assign c1_d = x1 & (y0_q ^ r_i[0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      y0_q <= 1'b0;
      y1_q <= 1'b0;
      u0_q <= 1'b0;
      u1_q <= 1'b0;
    end else if (en_p0_i) begin
      y0_q <= y0_d;
      y1_q <= y1_d;
      u0_q <= r_i[0] & ~x0;
      u1_q <= r_i[0] & ~x1;
    end
  end

  generate
    if (OUT_NEXT) begin : g_out_next
      // Last-level gadget: the consumer register samples on the phase-1 edge itself.
      assign f0_o = m0_d ^ c0_d ^ u0_q ^ z0_i;
      assign f1_o = m1_d ^ c1_d ^ u1_q ^ z1_i;
    end else begin : g_out_reg
      logic m0_q, m1_q, c0_q, c1_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          m0_q <= 1'b0;
          m1_q <= 1'b0;
          c0_q <= 1'b0;
          c1_q <= 1'b0;
        end else if (en_p1_i) begin
          m0_q <= m0_d;
          m1_q <= m1_d;
          c0_q <= c0_d;
          c1_q <= c1_d;
        end
      end

      assign f0_o = m0_q ^ c0_q ^ u0_q ^ z0_i;
      assign f1_o = m1_q ^ c1_q ^ u1_q ^ z1_i;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/skinny_sbox8_hpc2_1_mlane_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | skinny_sbox8_hpc2_1_mlane_hs                                               |
// | Multi-lane 2-share SKINNY S8 bank with valid/ready capture and output.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module skinny_sbox8_hpc2_1_mlane_hs
  import skinny_masked_pkg::*;
#(
  parameter int NUM_SBOX = 4,
  parameter int SW       = 8,
  parameter int RW       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SW*NUM_SBOX-1:0] si0,
  input  logic [SW*NUM_SBOX-1:0] si1,
  input  logic [RW*NUM_SBOX-1:0] rnd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SW*NUM_SBOX-1:0] bo0,
  output logic [SW*NUM_SBOX-1:0] bo1
);

  if (SW != skinny_masked_pkg::SW || RW != skinny_masked_pkg::RW ||
      NUM_SBOX < 1 || NUM_SBOX > 16) begin : g_param_check
    $error("skinny_sbox8_hpc2_1_mlane_hs: unsupported SW/RW/NUM_SBOX");
  end

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SW*NUM_SBOX-1:0] si0_q, si1_q, bo0_q, bo1_q, bo0_d, bo1_d;
  logic [RW*NUM_SBOX-1:0] rnd_q;
  logic [LEVELS-1:0]      en_p0, en_p1;
  logic                   run, last, accept;

  assign run       = (state_q == RUN);
  assign last      = run && (cnt_q == CNT_LAST);
  assign out_valid = (state_q == DONE);
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign bo0       = bo0_q;
  assign bo1       = bo1_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      si0_q <= '0;
      si1_q <= '0;
      rnd_q <= '0;
    end else if (accept) begin
      si0_q <= si0;
      si1_q <= si1;
      rnd_q <= rnd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bo0_q <= '0;
      bo1_q <= '0;
    end else if (last) begin
      bo0_q <= bo0_d;
      bo1_q <= bo1_d;
    end
  end

  // Level L owns cnt 2L (phase 0) and 2L+1 (phase 1).
  always_comb begin
    en_p0 = '0;
    en_p1 = '0;
    if (run) begin
      if (cnt_q[0]) en_p1[cnt_q[CNT_W-1:1]] = 1'b1;
      else          en_p0[cnt_q[CNT_W-1:1]] = 1'b1;
    end
  end

  generate
    for (genvar k = 0; k < NUM_SBOX; k++) begin : g_lane
      logic [SW-1:0]      b0, b1;
      logic [RW-1:0]      r;
      logic [NUM_CFN-2:0] fm0, fm1;
      logic [NUM_CFN-1:0] ga0, ga1;

      assign b0 = si0_q[k*SW +: SW];
      assign b1 = si1_q[k*SW +: SW];
      assign r  = rnd_q[k*RW +: RW];

      for (genvar g = 0; g < NUM_CFN; g++) begin : g_cfn
        localparam cfn_cfg_t CFG = cfn_cfg(g);
        logic o0, o1;

        hpc2_1_sbox8_cfn_sync #(
          .OUT_NEXT(g == NUM_CFN - 1)
        ) u_cfn (
          .clk     (clk),
          .rst     (rst),
          .en_p0_i (en_p0[CFG.level]),
          .en_p1_i (en_p1[CFG.level]),
          .a0_i    (pick(CFG.src_a, b0, fm0)),
          .a1_i    (pick(CFG.src_a, b1, fm1)),
          .b0_i    (pick(CFG.src_b, b0, fm0)),
          .b1_i    (pick(CFG.src_b, b1, fm1)),
          .z0_i    (b0[CFG.src_z]),
          .z1_i    (b1[CFG.src_z]),
          .r_i     (r[2*g +: 2]),
          .f0_o    (o0),
          .f1_o    (o1)
        );

        assign ga0[g] = o0;
        assign ga1[g] = o1;

        if (g < NUM_CFN - 1) begin : g_fwd
          assign fm0[g] = o0;
          assign fm1[g] = o1;
        end
      end

      assign bo0_d[k*SW +: SW] = perm_out(ga0);
      assign bo1_d[k*SW +: SW] = perm_out(ga1);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_skinny_sbox8_hpc2_1_mlane_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_skinny_sbox8_hpc2_1_mlane_hs                                            |
// | Directed, table-driven bench for the masked multi-lane S8 bank.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_skinny_sbox8_hpc2_1_mlane_hs;

  localparam int N   = 4;
  localparam int W   = 8 * N;
  localparam int RWD = 16 * N;

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]   si0, si1, bo0, bo1;
  logic [RWD-1:0] rnd;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
  } vec_t;

  vec_t       vecs[256];
  logic [7:0] sbox_tab[256];

  skinny_sbox8_hpc2_1_mlane_hs #(
    .NUM_SBOX(N), .SW(8), .RW(16)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .si0(si0), .si1(si1), .rnd(rnd), .out_valid(out_valid), .out_ready(out_ready),
    .bo0(bo0), .bo1(bo1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input logic [W-1:0] s0, input logic [W-1:0] s1,
                           input logic [RWD-1:0] r);
    int c;
    in_valid = 1'b1;
    si0      = s0;
    si1      = s1;
    rnd      = r;
    c        = 0;
    while (!in_ready && c < 40) begin
      step();
      c++;
    end
    chk("accept_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  // Seven RUN cycles with output low, then out_valid on the eighth edge.
  task automatic run_body(input bit scramble);
    for (int s = 0; s < 8; s++) begin
      if (scramble) begin
        si0      = $urandom;
        si1      = $urandom;
        rnd      = {$urandom, $urandom};
        in_valid = 1'($urandom_range(0, 1));
      end
      if (s == 7) chk("busy_flags", {out_valid, in_ready}, 2'b00);
      step();
    end
    in_valid = 1'b0;
    chk("latency_valid", out_valid, 1'b1);
  endtask

  task automatic check_lanes(input string name, input logic [W-1:0] xs);
    for (int k = 0; k < N; k++)
      chk($sformatf("%s_lane%0d", name, k), bo0[8*k +: 8] ^ bo1[8*k +: 8], sbox_tab[xs[8*k +: 8]]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0]   xs, s0, hold0, hold1;
    logic [RWD-1:0] r;
    bit             seen;

    sbox_tab = '{
      8'h65,8'h4c,8'h6a,8'h42,8'h4b,8'h63,8'h43,8'h6b,8'h55,8'h75,8'h5a,8'h7a,8'h53,8'h73,8'h5b,8'h7b,
      8'h35,8'h8c,8'h3a,8'h81,8'h89,8'h33,8'h80,8'h3b,8'h95,8'h25,8'h98,8'h2a,8'h90,8'h23,8'h99,8'h2b,
      8'he5,8'hcc,8'he8,8'hc1,8'hc9,8'he0,8'hc0,8'he9,8'hd5,8'hf5,8'hd8,8'hf8,8'hd0,8'hf0,8'hd9,8'hf9,
      8'ha5,8'h1c,8'ha8,8'h12,8'h1b,8'ha0,8'h13,8'ha9,8'h05,8'hb5,8'h0a,8'hb8,8'h03,8'hb0,8'h0b,8'hb9,
      8'h32,8'h88,8'h3c,8'h85,8'h8d,8'h34,8'h84,8'h3d,8'h91,8'h22,8'h9c,8'h2c,8'h94,8'h24,8'h9d,8'h2d,
      8'h62,8'h4a,8'h6c,8'h45,8'h4d,8'h64,8'h44,8'h6d,8'h52,8'h72,8'h5c,8'h7c,8'h54,8'h74,8'h5d,8'h7d,
      8'ha1,8'h1a,8'hac,8'h15,8'h1d,8'ha4,8'h14,8'had,8'h02,8'hb1,8'h0c,8'hbc,8'h04,8'hb4,8'h0d,8'hbd,
      8'he1,8'hc8,8'hec,8'hc5,8'hcd,8'he4,8'hc4,8'hed,8'hd1,8'hf1,8'hdc,8'hfc,8'hd4,8'hf4,8'hdd,8'hfd,
      8'h36,8'h8e,8'h38,8'h82,8'h8b,8'h30,8'h83,8'h39,8'h96,8'h26,8'h9a,8'h28,8'h93,8'h20,8'h9b,8'h29,
      8'h66,8'h4e,8'h68,8'h41,8'h49,8'h60,8'h40,8'h69,8'h56,8'h76,8'h58,8'h78,8'h50,8'h70,8'h59,8'h79,
      8'ha6,8'h1e,8'haa,8'h11,8'h19,8'ha3,8'h10,8'hab,8'h06,8'hb6,8'h08,8'hba,8'h00,8'hb3,8'h09,8'hbb,
      8'he6,8'hce,8'hea,8'hc2,8'hcb,8'he3,8'hc3,8'heb,8'hd6,8'hf6,8'hda,8'hfa,8'hd3,8'hf3,8'hdb,8'hfb,
      8'h31,8'h8a,8'h3e,8'h86,8'h8f,8'h37,8'h87,8'h3f,8'h92,8'h21,8'h9e,8'h2e,8'h97,8'h27,8'h9f,8'h2f,
      8'h61,8'h48,8'h6e,8'h46,8'h4f,8'h67,8'h47,8'h6f,8'h51,8'h71,8'h5e,8'h7e,8'h57,8'h77,8'h5f,8'h7f,
      8'ha2,8'h18,8'hae,8'h16,8'h1f,8'ha7,8'h17,8'haf,8'h01,8'hb2,8'h0e,8'hbe,8'h07,8'hb7,8'h0f,8'hbf,
      8'he2,8'hca,8'hee,8'hc6,8'hcf,8'he7,8'hc7,8'hef,8'hd2,8'hf2,8'hde,8'hfe,8'hd7,8'hf7,8'hdf,8'hff
    };
    for (int i = 0; i < 256; i++) begin
      vecs[i].x = 8'(i);
      vecs[i].y = sbox_tab[i];
    end

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; si0 = '0; si1 = '0; rnd = '0;
    step();
    step();
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_bo", {bo0, bo1}, '0);
    rst = 1'b0;

    // All-zero shares and randomness: every lane yields S8(00)=65.
    accept_op('0, '0, '0);
    run_body(1'b0);
    check_lanes("zero", '0);

    // x=FF with two different masks: same unmasked result, different share 0.
    accept_op({N{8'hA5}}, {N{8'h5A}}, 64'h0123_4567_89AB_CDEF);
    run_body(1'b0);
    check_lanes("ff_a", {N{8'hFF}});
    hold0 = bo0;
    accept_op({N{8'hA5}}, {N{8'h5A}}, 64'hF00D_BEEF_5A5A_3C3C);
    run_body(1'b0);
    check_lanes("ff_b", {N{8'hFF}});
    chk("share_refresh", bo0 != hold0, 1'b1);

    // Exhaustive table, back-to-back, inputs scrambled during RUN.
    for (int i = 0; i < 64; i++) begin
      xs = {vecs[i+192].x, vecs[i+128].x, vecs[i+64].x, vecs[i].x};
      s0 = $urandom;
      r  = {$urandom, $urandom};
      accept_op(s0, s0 ^ xs, r);
      run_body(1'b1);
      for (int k = 0; k < N; k++)
        chk($sformatf("table_x%02h", vecs[i+64*k].x), bo0[8*k +: 8] ^ bo1[8*k +: 8], vecs[i+64*k].y);
    end

    // Output stall: DONE holds, new request ignored, then handoff+accept on one edge.
    xs = 32'h00_01_10_80;
    accept_op(32'h1234_5678, 32'h1234_5678 ^ xs, 64'hDEAD_0000_BEEF_1111);
    run_body(1'b0);
    check_lanes("pre_stall", xs);
    hold0     = bo0;
    hold1     = bo1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    si0       = 32'hCAFE_F00D;
    si1       = 32'hCAFE_F00D ^ 32'h5A_A5_FF_3C;
    rnd       = 64'h1111_2222_3333_4444;
    for (int c = 0; c < 20; c++) begin
      step();
      chk("stall", {out_valid, in_ready, bo0, bo1}, {1'b1, 1'b0, hold0, hold1});
    end
    out_ready = 1'b1;
    accept_op(32'hCAFE_F00D, 32'hCAFE_F00D ^ 32'h5A_A5_FF_3C, 64'h1111_2222_3333_4444);
    chk("handoff_out_valid", out_valid, 1'b0);
    run_body(1'b1);
    check_lanes("post_stall", 32'h5A_A5_FF_3C);

    // Reset in the middle of an operation at cnt=4.
    accept_op(32'h0F0F_0F0F, 32'hF0F0_F0F0 ^ 32'h0F0F_0F0F, 64'h0BAD_C0DE_1234_9876);
    for (int c = 0; c < 4; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_bo", {bo0, bo1}, '0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (out_valid) seen = 1'b1;
    end
    chk("midrst_discard", seen, 1'b0);
    xs = 32'h7E_3C_81_42;
    accept_op(32'h5555_AAAA, 32'h5555_AAAA ^ xs, 64'h0F1E_2D3C_4B5A_6978);
    run_body(1'b1);
    check_lanes("after_rst", xs);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
